// File: rtl/ex_mem_pipe_if.sv
// EX->MEM handshake bundle: EX-side request, MEM-side response and the forwarding tap.
// master = EX/MEM environment side, slave = the pipeline stage.
interface ex_mem_pipe_if #(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_rd_we;
  logic [RAW-1:0]    in_rd_addr;
  logic [XLEN-1:0]   in_rd_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic              out_rd_we;
  logic [RAW-1:0]    out_rd_addr;
  logic [XLEN-1:0]   out_rd_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              fwd_we;

  modport master (
    output in_valid, in_rd_we, in_rd_addr, in_rd_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_rd_we, out_rd_addr, out_rd_data, out_ctrl, fwd_we
  );

  modport slave (
    input  in_valid, in_rd_we, in_rd_addr, in_rd_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_rd_we, out_rd_addr, out_rd_data, out_ctrl, fwd_we
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and write-back forwarding tap.
// Build option EX_MEM_SKID_EN: two-entry skid buffer with registered in_ready.
module ex_mem_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int CTRL_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  ex_mem_pipe_if.slave    bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t            state;
  logic              vld_p1;
  logic              rd_we_p1;
  logic [RAW-1:0]    rd_addr_p1;
  logic [XLEN-1:0]   rd_data_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = vld_p1 & bus.out_ready;

`ifdef EX_MEM_SKID_EN
  logic              in_rdy;
  logic              rd_we_p0;
  logic [RAW-1:0]    rd_addr_p0;
  logic [XLEN-1:0]   rd_data_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  // in_ready is registered so out_ready never reaches it combinationally
  assign bus.in_ready = in_rdy;

  // ---- stage p0 (skid) / p1 (output register) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      vld_p1     <= 1'b0;
      in_rdy     <= 1'b1;
      rd_we_p1   <= 1'b0;
      rd_addr_p1 <= '0;
      rd_data_p1 <= '0;
      ctrl_p1    <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      vld_p1 <= 1'b0;
      in_rdy <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state      <= BUSY;
          vld_p1     <= 1'b1;
          rd_we_p1   <= bus.in_rd_we;
          rd_addr_p1 <= bus.in_rd_addr;
          rd_data_p1 <= bus.in_rd_data;
          ctrl_p1    <= bus.in_ctrl;
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state      <= FULL;
            in_rdy     <= 1'b0;
            rd_we_p0   <= bus.in_rd_we;
            rd_addr_p0 <= bus.in_rd_addr;
            rd_data_p0 <= bus.in_rd_data;
            ctrl_p0    <= bus.in_ctrl;
          end else if (in_fire && out_fire) begin
            rd_we_p1   <= bus.in_rd_we;
            rd_addr_p1 <= bus.in_rd_addr;
            rd_data_p1 <= bus.in_rd_data;
            ctrl_p1    <= bus.in_ctrl;
          end else if (out_fire) begin
            state  <= EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        FULL: if (out_fire) begin
          state      <= BUSY;
          in_rdy     <= 1'b1;
          rd_we_p1   <= rd_we_p0;
          rd_addr_p1 <= rd_addr_p0;
          rd_data_p1 <= rd_data_p0;
          ctrl_p1    <= ctrl_p0;
        end
        default: begin
          state  <= EMPTY;
          vld_p1 <= 1'b0;
          in_rdy <= 1'b1;
        end
      endcase
    end
  end
`else
  assign bus.in_ready = ~vld_p1 | bus.out_ready;

  // ---- stage p1 (output register) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      vld_p1     <= 1'b0;
      rd_we_p1   <= 1'b0;
      rd_addr_p1 <= '0;
      rd_data_p1 <= '0;
      ctrl_p1    <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      state      <= BUSY;
      vld_p1     <= 1'b1;
      rd_we_p1   <= bus.in_rd_we;
      rd_addr_p1 <= bus.in_rd_addr;
      rd_data_p1 <= bus.in_rd_data;
      ctrl_p1    <= bus.in_ctrl;
    end else if (out_fire) begin
      state  <= EMPTY;
      vld_p1 <= 1'b0;
    end
  end
`endif

  assign bus.out_valid   = vld_p1;
  assign bus.out_rd_we   = vld_p1 & rd_we_p1;
  assign bus.out_rd_addr = rd_addr_p1;
  assign bus.out_rd_data = rd_data_p1;
  assign bus.out_ctrl    = ctrl_p1;
  // x0 writes still flow to MEM; only the bypass tap ignores them
  assign bus.fwd_we      = vld_p1 & rd_we_p1 & (rd_addr_p1 != '0);

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: FIFO reference model plus directed pins.
module tb_ex_mem_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ex_mem_pipe_if #(.XLEN(32), .RAW(5), .CTRL_W(4)) bus ();

  ex_mem_pipe_stage #(.XLEN(32), .RAW(5), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  ctrl;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  seen[$];
  int          errors = 0;
  int          checks = 0;
  bit          started = 0;

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  function automatic logic exp_rdy();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || bus.out_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of accepted instructions
  always @(posedge clk) begin
    logic pop, push;
    if (rst) begin
      q.delete();
      started = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      pop  = (q.size() != 0) && bus.out_ready;
      push = bus.in_valid && exp_rdy();
      if (pop) begin
        seen.push_back(q[0].addr);
        void'(q.pop_front());
      end
      if (push) q.push_back({bus.in_rd_we, bus.in_rd_addr, bus.in_rd_data, bus.in_ctrl});
      if (q.size() > CAP) begin
        errors++;
        $display("FAIL model_capacity: got %0d expected <=%0d", q.size(), CAP);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("in_ready", bus.in_ready, exp_rdy());
      if (q.size() != 0) begin
        chk("out_rd_addr", bus.out_rd_addr, q[0].addr);
        chk("out_rd_data", bus.out_rd_data, q[0].data);
        chk("out_ctrl", bus.out_ctrl, q[0].ctrl);
        chk("out_rd_we", bus.out_rd_we, q[0].we);
        chk("fwd_we", bus.fwd_we, q[0].we && (q[0].addr != 0));
      end else begin
        chk("out_rd_we_idle", bus.out_rd_we, 0);
        chk("fwd_we_idle", bus.fwd_we, 0);
      end
    end
  end

  task automatic send(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] c, output int waited);
    logic acc;
    bus.in_valid   = 1'b1;
    bus.in_rd_we   = we;
    bus.in_rd_addr = a;
    bus.in_rd_data = d;
    bus.in_ctrl    = c;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(posedge clk);
      waited++;
      acc = bus.in_ready && !flush && !rst;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: addr %0d not accepted within %0d cycles", a, waited);
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_stream();
    int w;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, 5'(i), 32'h100 + 32'(i), 4'(i), w);
      chk("stream_latency", w, 1);
      chk("stream_addr", bus.out_rd_addr, 32'(i));
      chk("stream_data", bus.out_rd_data, 32'h100 + 32'(i));
      chk("stream_valid", bus.out_valid, 1);
    end
    idle(2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_rd_we"}, bus.out_rd_we, 0);
    chk({tag, "_rd_addr"}, bus.out_rd_addr, 0);
    chk({tag, "_rd_data"}, bus.out_rd_data, 0);
    chk({tag, "_ctrl"}, bus.out_ctrl, 0);
    chk({tag, "_fwd_we"}, bus.fwd_we, 0);
  endtask

  initial begin
    int w, n;
    bus.in_valid = 0; bus.in_rd_we = 0; bus.in_rd_addr = 0;
    bus.in_rd_data = 0; bus.in_ctrl = 0; bus.out_ready = 0;

    // reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(1);
    check_reset_vals("reset");

    // back-to-back stream, no bubbles
    run_stream();

    // back-pressure: three instructions against a 4-cycle stall
    bus.out_ready = 1'b0;
    fork
      begin
        send(1'b1, 5'd21, 32'hA21, 4'h1, w);
        send(1'b1, 5'd22, 32'hA22, 4'h2, w);
        send(1'b1, 5'd23, 32'hA23, 4'h3, w);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk); #1;
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_hold_addr", bus.out_rd_addr, 21);
        repeat (2) @(negedge clk); #1;
        chk("stall_hold_addr2", bus.out_rd_addr, 21);
        chk("stall_hold_data", bus.out_rd_data, 32'hA21);
        bus.out_ready = 1'b1;
      end
    join
    idle(4);
    chk("order_1", seen[seen.size()-3], 21);
    chk("order_2", seen[seen.size()-2], 22);
    chk("order_3", seen[seen.size()-1], 23);

    // flush while held, with a concurrent input
    bus.out_ready = 1'b0;
    send(1'b1, 5'd31, 32'hB31, 4'h0, w);
    if (CAP == 2) send(1'b1, 5'd32, 32'hB32, 4'h0, w);
    bus.in_valid = 1'b1; bus.in_rd_addr = 5'd33; bus.in_rd_data = 32'hB33;
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    n = seen.size();
    bus.out_ready = 1'b1;
    idle(3);
    chk("flush_nothing_out", seen.size(), n);

    // x0 write passes through but is masked from forwarding
    send(1'b1, 5'd0, 32'hDEADBEEF, 4'h5, w);
    chk("x0_rd_we", bus.out_rd_we, 1);
    chk("x0_fwd_we", bus.fwd_we, 0);
    chk("x0_data", bus.out_rd_data, 32'hDEADBEEF);
    send(1'b1, 5'd5, 32'h55, 4'h5, w);
    chk("x5_fwd_we", bus.fwd_we, 1);
    idle(2);

    // reset while stalled
    bus.out_ready = 1'b0;
    send(1'b1, 5'd41, 32'hC41, 4'h7, w);
    if (CAP == 2) send(1'b1, 5'd42, 32'hC42, 4'h7, w);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_reset_vals("midrst");
    run_stream();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_rd_we   = $urandom_range(0, 1);
      bus.in_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.in_rd_data = $urandom;
      bus.in_ctrl    = 4'($urandom);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 40) == 0);
      rst            = ($urandom_range(0, 300) == 0);
      @(negedge clk); #1;
    end
    flush = 1'b0; rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
